// File: rtl/instr_encoder_if.sv
// Request and IMEM write-port bundle for instr_encoder.
// master = program builder (issues requests), slave = encoder.
interface instr_encoder_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [4:0]        req_op;
   logic [4:0]        req_rd;
   logic [4:0]        req_rs1;
   logic [4:0]        req_rs2;
   logic [31:0]       req_imm;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
      input  req_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
      output req_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instr_encoder.sv
// Sequential RV32I encoder: symbolic requests in, instruction words out to the IMEM write port
// at auto-incrementing addresses. LI expands to LUI+ADDI when the value needs it.
module instr_encoder #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic            clk,
   input  logic            rst,
   instr_encoder_if.slave  bus,
   output logic [ADDR_W:0] count,
   output logic            imm_err
);

   typedef enum logic [4:0] {
      op_add, op_sub, op_and, op_or, op_xor, op_slt, op_sltu, op_sll, op_srl, op_sra,
      op_addi, op_andi, op_ori, op_xori, op_slti, op_sltiu, op_slli, op_srli, op_srai,
      op_lui, op_auipc, op_jal, op_jalr, op_lw, op_sw,
      op_beq, op_bne, op_blt, op_bge, op_bltu, op_bgeu, op_li
   } op_e;

   typedef enum logic [1:0] {st_idle, st_emit2, st_full} state_e;

   localparam logic [ADDR_W:0]   cap  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   one  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   two  = (ADDR_W+1)'(2);
   localparam logic [ADDR_W-1:0] base = BASE_ADDR[ADDR_W-1:0];

   localparam logic [6:0] opc_r     = 7'b0110011;
   localparam logic [6:0] opc_imm   = 7'b0010011;
   localparam logic [6:0] opc_lui   = 7'b0110111;
   localparam logic [6:0] opc_auipc = 7'b0010111;
   localparam logic [6:0] opc_jal   = 7'b1101111;
   localparam logic [6:0] opc_jalr  = 7'b1100111;
   localparam logic [6:0] opc_load  = 7'b0000011;
   localparam logic [6:0] opc_store = 7'b0100011;
   localparam logic [6:0] opc_br    = 7'b1100011;

   state_e            state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [4:0]        li_rd_q, li_rd_d;
   logic [11:0]       li_lo_q, li_lo_d;

   op_e         op;
   logic [31:0] imm;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [6:0]  i_opc;
   logic        i_ok, b_ok, j_ok;
   logic [19:0] li_hi;
   logic [31:0] enc_word;
   logic        enc_err, two_word;
   logic        ready;
   logic [ADDR_W:0] free, count_inc;

   assign op  = op_e'(bus.req_op);
   assign imm = bus.req_imm;
   assign rd  = bus.req_rd;
   assign rs1 = bus.req_rs1;
   assign rs2 = bus.req_rs2;

   assign i_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
   assign b_ok = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
   assign j_ok = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];
   // (imm + 0x800) >> 12 compensates for ADDI sign-extending the low 12 bits
   assign li_hi = imm[31:12] + {19'd0, imm[11]};

   always_comb begin
      f3 = 3'b000;
      case (op)
         op_sll, op_slli, op_bne:            f3 = 3'b001;
         op_slt, op_slti, op_lw, op_sw:      f3 = 3'b010;
         op_sltu, op_sltiu:                  f3 = 3'b011;
         op_xor, op_xori, op_blt:            f3 = 3'b100;
         op_srl, op_sra, op_srli, op_srai,
         op_bge:                             f3 = 3'b101;
         op_or, op_ori, op_bltu:             f3 = 3'b110;
         op_and, op_andi, op_bgeu:           f3 = 3'b111;
         default:                            f3 = 3'b000;
      endcase
   end

   always_comb begin
      i_opc = opc_imm;
      if (op == op_jalr) i_opc = opc_jalr;
      else if (op == op_lw) i_opc = opc_load;
   end

   always_comb begin
      enc_word = '0;
      enc_err  = 1'b0;
      two_word = 1'b0;
      case (op)
         op_add, op_sub, op_and, op_or, op_xor, op_slt, op_sltu, op_sll, op_srl, op_sra:
            enc_word = {1'b0, (op == op_sub) || (op == op_sra), 5'd0, rs2, rs1, f3, rd, opc_r};
         op_addi, op_andi, op_ori, op_xori, op_slti, op_sltiu, op_jalr, op_lw: begin
            enc_word = {imm[11:0], rs1, f3, rd, i_opc};
            enc_err  = !i_ok;
         end
         op_slli, op_srli, op_srai: begin
            enc_word = {1'b0, op == op_srai, 5'd0, imm[4:0], rs1, f3, rd, opc_imm};
            enc_err  = imm[31:5] != '0;
         end
         op_lui, op_auipc: begin
            enc_word = {imm[19:0], rd, (op == op_lui) ? opc_lui : opc_auipc};
            enc_err  = imm[31:20] != '0;
         end
         op_jal: begin
            enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc_jal};
            enc_err  = !j_ok;
         end
         op_sw: begin
            enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc_store};
            enc_err  = !i_ok;
         end
         op_beq, op_bne, op_blt, op_bge, op_bltu, op_bgeu: begin
            enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc_br};
            enc_err  = !b_ok;
         end
         op_li: begin
            if (i_ok) begin
               enc_word = {imm[11:0], 5'd0, 3'b000, rd, opc_imm};
            end else begin
               enc_word = {li_hi, rd, opc_lui};
               two_word = imm[11:0] != '0;
            end
         end
         default: ;
      endcase
   end

   assign free      = cap - count_q;
   assign count_inc = count_q + one;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      addr_d  = addr_q;
      we_d    = 1'b0;
      wdata_d = wdata_q;
      err_d   = err_q;
      li_rd_d = li_rd_q;
      li_lo_d = li_lo_q;
      ready   = 1'b0;
      case (state_q)
         st_idle: begin
            ready = (op == op_li) ? (free >= two) : (free >= one);
            if (bus.req_valid && ready) begin
               we_d    = 1'b1;
               wdata_d = enc_word;
               addr_d  = base + count_q[ADDR_W-1:0];
               count_d = count_inc;
               err_d   = err_q | enc_err;
               if (two_word) begin
                  state_d = st_emit2;
                  li_rd_d = rd;
                  li_lo_d = imm[11:0];
               end else if (count_inc == cap) begin
                  state_d = st_full;
               end
            end
         end
         st_emit2: begin
            we_d    = 1'b1;
            wdata_d = {li_lo_q, li_rd_q, 3'b000, li_rd_q, opc_imm};
            addr_d  = base + count_q[ADDR_W-1:0];
            count_d = count_inc;
            state_d = (count_inc == cap) ? st_full : st_idle;
         end
         st_full: ;
         default: state_d = st_idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= st_idle;
         count_q <= '0;
         addr_q  <= base;
         we_q    <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         li_rd_q <= '0;
         li_lo_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         li_rd_q <= li_rd_d;
         li_lo_q <= li_lo_d;
      end
   end

   assign bus.req_ready  = ready;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign count          = count_q;
   assign imm_err        = err_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential RV32I instruction encoder, the inverse of the core's control decoder.
- Accepts symbolic operation requests (op, rd, rs1, rs2, imm) over a valid/ready handshake and emits 32-bit instruction words into the instruction-memory write port at auto-incrementing word addresses.
- Expands the LI pseudo-op into LUI+ADDI.
- Used by the testbench/boot loader to build programs in IMEM before the core is released.

Parameters:
- ADDR_W, 8, IMEM word-address width; capacity is 2**ADDR_W words.
- BASE_ADDR, 0, first word address written after reset.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  encoder can accept req_op this cycle
- req_op  in  5  0-9 ADD,SUB,AND,OR,XOR,SLT,SLTU,SLL,SRL,SRA; 10-18 ADDI,ANDI,ORI,XORI,SLTI,SLTIU,SLLI,SRLI,SRAI; 19 LUI; 20 AUIPC; 21 JAL; 22 JALR; 23 LW; 24 SW; 25-30 BEQ,BNE,BLT,BGE,BLTU,BGEU; 31 LI
- req_rd / req_rs1 / req_rs2  in  5 each  register indices
- req_imm  in  32  signed immediate; byte offset for branches/JAL; upper-20 value in [19:0] for LUI/AUIPC
- imem_we  out  1  write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written since reset
- imm_err  out  1  sticky: an immediate was out of range

Behaviour:
- Reset: all outputs 0, imem_addr=BASE_ADDR, state IDLE.
- Outputs are registered. A request accepted in cycle N gives imem_we=1 in N+1 with imem_addr=BASE_ADDR+count(pre-increment). count increments in the same cycle as each write.
- States:
  - IDLE: ready = (free>=2) if req_op==31, else (free>=1); free = 2**ADDR_W - count.
  - EMIT2: second word of a two-word LI; ready=0; returns to IDLE next cycle.
  - FULL: count == 2**ADDR_W; ready=0; held until rst.
- req_ready depends combinationally on req_op only. A held request must keep req_op stable until accepted.
- Encodings are standard RV32I:
  - R: funct7=0100000 for SUB/SRA.
  - I-shifts: shamt=imm[4:0]; SRAI sets funct7=0100000.
  - LW/SW: funct3=010.
  - JALR: funct3=000.
  - B/J: imm bit 0 dropped.
  - Unused fields (rs2 for I, rd for S/B, etc.) are 0.
- LI:
  - If imm in [-2048,2047]: single ADDI rd,x0,imm.
  - Else hi=(imm+0x800)>>12 (logical, 20 bits). If imm[11:0]==0: single LUI rd,hi. Otherwise LUI rd,hi in N+1, then ADDI rd,rd,imm[11:0] in N+2 via EMIT2.
- imm_err: set (stays set until rst) when any of these holds:
  - I/S imm outside [-2048,2047].
  - Shift imm > 31.
  - B imm outside [-4096,4094] or odd.
  - J imm outside [-1048576,1048574] or odd.
  - LUI/AUIPC imm[31:20] != 0.
  The word is still emitted with truncated fields.
- Address wrap: imem_addr increments modulo 2**ADDR_W. Reaching count==2**ADDR_W enters FULL, so no address is overwritten.
- rst asserted in any state, including EMIT2, aborts any pending second word. No write occurs in the cycle after rst.
- req_valid while ready=0 is ignored. The request is not consumed.

Test Plan:
- Reset, ADD rd=3 rs1=1 rs2=2 -> next cycle imem_we=1, addr=0, wdata=0x002081B3, count=1.
- ADDI rd=1 rs1=0 imm=-1 -> 0xFFF00093; SRAI rd=1 rs1=1 imm=3 -> 0x4030D093; imm_err stays 0.
- LI rd=5 imm=0x12345FFF -> two consecutive writes 0x123462B7 then 0xFFF28293. req_ready=0 during the EMIT2 cycle; count +2. LI imm=100 -> single 0x06400293.
- SW rs1=1 rs2=2 imm=8 -> 0x0020A423; BEQ rs1=1 rs2=2 imm=-8 -> 0xFE208CE3; BEQ imm=5 -> imm_err=1 and stays set after further valid requests.
- ADDR_W=2: three ADDs, then LI imm=0x12345FFF -> req_ready=0 (free=1). Switching to ADD is accepted (addr=3), then FULL: req_ready=0 for all ops, count=4, no further imem_we.
- Assert rst in the EMIT2 cycle of a two-word LI -> no ADDI write, count=0, imem_addr=BASE_ADDR. Next ADD is written at BASE_ADDR.
